// File: rtl/serial_adder_8bit_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_8bit_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width; must hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_8bit_full_adder.sv
// One-bit full adder used as the serial bit slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial a + b + cin, LSB first, one full-adder slice plus carry flop,
// with start/ready/done handshake.
module serial_adder_8bit
  import serial_adder_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // Last bit: the MSB sum bit is fa_sum, so overflow uses it directly.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (fa_sum != a_msb_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
